// File: rtl/hw_cfg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// hw_cfg_arbiter_pkg : shared types and constants for the config-bus arbiter
// Rev 1.0
// ============================================================================
package hw_cfg_arbiter_pkg;

    localparam int PAYLOAD_W = 24;
    localparam int CFG16_W   = 16;

    typedef logic [1:0] tgt_t;

    localparam tgt_t TGT_AD9518 = 2'd0;
    localparam tgt_t TGT_AD9122 = 2'd1;
    localparam tgt_t TGT_DAC124 = 2'd2;
    localparam tgt_t TGT_INV    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_req_slot.sv
`default_nettype none
// ============================================================================
// cfg_req_slot : one-entry valid/ready holding register for a requester
// Rev 1.0
// ============================================================================
module cfg_req_slot
    import hw_cfg_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  tgt_t                 tgt_i,
    input  logic [PAYLOAD_W-1:0] data_i,
    input  logic                 clear_i,
    output logic                 ready_o,
    output logic                 pending_o,
    output tgt_t                 tgt_o,
    output logic [PAYLOAD_W-1:0] data_o
);

    logic                 pending_q;
    tgt_t                 tgt_q;
    logic [PAYLOAD_W-1:0] data_q;
    logic                 w_accept;

    assign ready_o  = !pending_q;
    assign w_accept = valid_i && !pending_q;

    // Accept and clear never coincide: clear only happens while pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            tgt_q     <= TGT_AD9518;
            data_q    <= '0;
        end else if (w_accept) begin
            pending_q <= 1'b1;
            tgt_q     <= tgt_i;
            data_q    <= data_i;
        end else if (clear_i) begin
            pending_q <= 1'b0;
        end
    end

    assign pending_o = pending_q;
    assign tgt_o     = tgt_q;
    assign data_o    = data_q;

endmodule
`default_nettype wire

// File: rtl/hw_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// hw_cfg_arbiter : round-robin arbiter issuing CONFIG_EN pulses with guard gaps
// Rev 1.0
// ============================================================================
module hw_cfg_arbiter
    import hw_cfg_arbiter_pkg::*;
#(
    parameter int GAP_AD9518 = 64,
    parameter int GAP_AD9122 = 48,
    parameter int GAP_DAC124 = 40
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0_VALID,
    output logic                 REQ0_READY,
    input  logic [1:0]           REQ0_TGT,
    input  logic [PAYLOAD_W-1:0] REQ0_DATA,
    input  logic                 REQ1_VALID,
    output logic                 REQ1_READY,
    input  logic [1:0]           REQ1_TGT,
    input  logic [PAYLOAD_W-1:0] REQ1_DATA,
    output logic                 AD9518_CONFIG_EN,
    output logic [PAYLOAD_W-1:0] AD9518_CONFIG_DATA,
    output logic                 AD9122_CONFIG_EN,
    output logic [CFG16_W-1:0]   AD9122_CONFIG_DATA,
    output logic                 DAC124_CONFIG_EN,
    output logic [CFG16_W-1:0]   DAC124_CONFIG_DATA,
    output logic                 BUSY,
    output logic                 ERR_TGT
);

    localparam int GAP_MAX = max3(GAP_AD9518, GAP_AD9122, GAP_DAC124);
    localparam int CNT_W   = $clog2(GAP_MAX + 1);

    logic                 w_pend0, w_pend1;
    tgt_t                 w_tgt0, w_tgt1;
    logic [PAYLOAD_W-1:0] w_data0, w_data1;
    logic                 w_gnt, w_sel;
    tgt_t                 w_gnt_tgt;
    logic [PAYLOAD_W-1:0] w_gnt_data;

    state_t               state_q;
    logic                 last_q;
    logic [CNT_W-1:0]     cnt_q;
    tgt_t                 issue_tgt_q;
    logic                 en518_q, en9122_q, en124_q;
    logic [PAYLOAD_W-1:0] d518_q;
    logic [CFG16_W-1:0]   d9122_q, d124_q;
    logic                 busy_q, err_q;

    cfg_req_slot u_slot0 (
        .clk_i     (CLK),
        .rst_i     (RST),
        .valid_i   (REQ0_VALID),
        .tgt_i     (REQ0_TGT),
        .data_i    (REQ0_DATA),
        .clear_i   (w_gnt && !w_sel),
        .ready_o   (REQ0_READY),
        .pending_o (w_pend0),
        .tgt_o     (w_tgt0),
        .data_o    (w_data0)
    );

    cfg_req_slot u_slot1 (
        .clk_i     (CLK),
        .rst_i     (RST),
        .valid_i   (REQ1_VALID),
        .tgt_i     (REQ1_TGT),
        .data_i    (REQ1_DATA),
        .clear_i   (w_gnt && w_sel),
        .ready_o   (REQ1_READY),
        .pending_o (w_pend1),
        .tgt_o     (w_tgt1),
        .data_o    (w_data1)
    );

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        w_sel = 1'b0;
        if (w_pend0 && w_pend1) begin
            w_sel = !last_q;
        end else if (w_pend1) begin
            w_sel = 1'b1;
        end
        w_gnt      = (state_q == ST_IDLE) && (w_pend0 || w_pend1);
        w_gnt_tgt  = w_sel ? w_tgt1  : w_tgt0;
        w_gnt_data = w_sel ? w_data1 : w_data0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            issue_tgt_q <= TGT_AD9518;
            en518_q     <= 1'b0;
            en9122_q    <= 1'b0;
            en124_q     <= 1'b0;
            d518_q      <= '0;
            d9122_q     <= '0;
            d124_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            en518_q  <= 1'b0;
            en9122_q <= 1'b0;
            en124_q  <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (w_gnt) begin
                        last_q <= w_sel;
                        if (w_gnt_tgt == TGT_INV) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            busy_q      <= 1'b1;
                            issue_tgt_q <= w_gnt_tgt;
                            if (w_gnt_tgt == TGT_AD9518) begin
                                en518_q <= 1'b1;
                                d518_q  <= w_gnt_data;
                            end else if (w_gnt_tgt == TGT_AD9122) begin
                                en9122_q <= 1'b1;
                                d9122_q  <= w_gnt_data[CFG16_W-1:0];
                            end else begin
                                en124_q <= 1'b1;
                                d124_q  <= w_gnt_data[CFG16_W-1:0];
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_GAP;
                    if (issue_tgt_q == TGT_AD9518) begin
                        cnt_q <= CNT_W'(GAP_AD9518 - 1);
                    end else if (issue_tgt_q == TGT_AD9122) begin
                        cnt_q <= CNT_W'(GAP_AD9122 - 1);
                    end else begin
                        cnt_q <= CNT_W'(GAP_DAC124 - 1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign AD9518_CONFIG_EN   = en518_q;
    assign AD9518_CONFIG_DATA = d518_q;
    assign AD9122_CONFIG_EN   = en9122_q;
    assign AD9122_CONFIG_DATA = d9122_q;
    assign DAC124_CONFIG_EN   = en124_q;
    assign DAC124_CONFIG_DATA = d124_q;
    assign BUSY               = busy_q;
    assign ERR_TGT            = err_q;

endmodule
`default_nettype wire
